// File: rtl/alu_seq_flags_if.sv
// Request/response bundle between the execute stage and its ALU.
// The master issues operations; the slave (ALU) returns the results.
interface alu_seq_flags_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] alu_out;
  logic             zout;
  logic             branch_taken;
  logic             illegal;

  modport master (
    output in_valid, alu_control, a, b,
    input  in_ready, out_valid, alu_out,
    input  zout, branch_taken, illegal
  );

  modport slave (
    input  in_valid, alu_control, a, b,
    output in_ready, out_valid, alu_out,
    output zout, branch_taken, illegal
  );
endinterface

// File: rtl/alu_seq_flags.sv
// Execute-stage ALU: N/V/Z flags, branch evaluation, serial shifts.
// Define ALU_MUL_EN to add the iterative multiply on opcode 1100.
module alu_seq_flags #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_seq_flags_if.slave bus,
  input  logic         jump,
  output logic [2:0]   flags,
  output logic         busy
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_BEN = 4'b1000;
  localparam logic [3:0] OP_BVF = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1011;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1100;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef ALU_MUL_EN
    , S_MUL
`endif
  } state_t;

  state_t           state;
  logic             pend;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH:0]     p_hi;
`endif

  logic             accept;
  logic             done;
  logic             is_shift;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [2:0]       nf;
  logic             br;
  logic             ill;

  assign bus.in_ready = (state == S_IDLE);
  assign busy         = ~bus.in_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  // A pending op completes once any multi-cycle work has drained.
  assign done         = pend & (state == S_IDLE);
  assign shamt        = bus.b[SH_W-1:0];
  assign is_shift     = (bus.alu_control == OP_SLL) |
                        (bus.alu_control == OP_SRL);
  assign sum          = a_q + b_q;
  assign dif          = a_q - b_q;
`ifdef ALU_MUL_EN
  assign p_hi = {1'b0, p_q[2*WIDTH-1:WIDTH]} +
                (p_q[0] ? {1'b0, a_q} : '0);
`endif

  always_comb begin
    r   = bus.alu_out;
    nf  = flags;
    br  = 1'b0;
    ill = 1'b0;
    unique case (1'b1)
      op_q == OP_ADD: begin
        r  = sum;
        nf = {sum[WIDTH-1],
              (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
              (sum[WIDTH-1] != a_q[WIDTH-1]),
              ~|sum};
      end
      op_q == OP_SUB: begin
        r  = dif;
        nf = {dif[WIDTH-1],
              (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
              (dif[WIDTH-1] != a_q[WIDTH-1]),
              ~|dif};
      end
      op_q == OP_SLT: begin
        r  = {{(WIDTH-1){1'b0}},
              $signed(a_q) < $signed(b_q)};
        nf = 3'b000;
      end
      op_q == OP_AND: begin
        r  = a_q & b_q;
        nf = {r[WIDTH-1], 1'b0, ~|r};
      end
      op_q == OP_OR: begin
        r  = a_q | b_q;
        nf = {r[WIDTH-1], 1'b0, ~|r};
      end
      op_q == OP_XOR: begin
        r  = a_q ^ b_q;
        nf = {r[WIDTH-1], 1'b0, ~|r};
      end
      op_q == OP_NOR: begin
        r  = ~(a_q | b_q);
        nf = {r[WIDTH-1], 1'b0, ~|r};
      end
      (op_q == OP_SLL) || (op_q == OP_SRL): begin
        r  = acc;
        nf = {r[WIDTH-1], 1'b0, ~|r};
      end
      // Branches test the flags left by the previous op.
      op_q == OP_BVF: begin
        br = flags[1];
        nf = 3'b000;
      end
      op_q == OP_BEN: begin
        br = flags[0] | flags[2];
        nf = 3'b000;
      end
`ifdef ALU_MUL_EN
      op_q == OP_MUL: begin
        r  = p_q[WIDTH-1:0];
        nf = {r[WIDTH-1],
              |p_q[2*WIDTH-1:WIDTH],
              ~|r};
      end
`endif
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      pend             <= 1'b0;
      op_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      acc              <= '0;
      cnt              <= '0;
`ifdef ALU_MUL_EN
      p_q              <= '0;
`endif
      flags            <= 3'b000;
      bus.out_valid    <= 1'b0;
      bus.alu_out      <= '0;
      bus.zout         <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.illegal      <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (done) begin
        pend             <= 1'b0;
        bus.out_valid    <= 1'b1;
        bus.alu_out      <= r;
        bus.zout         <= ~|r;
        bus.branch_taken <= br;
        bus.illegal      <= ill;
        flags            <= nf;
      end
      if (accept) begin
        pend <= 1'b1;
        op_q <= bus.alu_control;
        a_q  <= bus.a;
        b_q  <= bus.b;
        acc  <= bus.a;
        cnt  <= CNT_W'(shamt);
        if (is_shift && shamt != '0)
          state <= S_SHIFT;
`ifdef ALU_MUL_EN
        if (bus.alu_control == OP_MUL) begin
          state <= S_MUL;
          cnt   <= CNT_W'(WIDTH);
          p_q   <= {{WIDTH{1'b0}}, bus.b};
        end
`endif
      end
      case (state)
        S_SHIFT: begin
          acc <= (op_q == OP_SLL) ? acc << 1
                                  : acc >> 1;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= S_IDLE;
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          p_q <= {p_hi, p_q[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= S_IDLE;
        end
`endif
        default: ;
      endcase
      // A jump always leaves the flags clear, even over a completion.
      if (jump)
        flags <= 3'b000;
    end
  end
endmodule

// File: tb/tb_alu_seq_flags.sv
// Scoreboard bench for alu_seq_flags: directed cases plus random ops
// against an arithmetic reference model.
module tb_alu_seq_flags;
  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       jump = 1'b0;
  logic [2:0] flags;
  logic       busy;
  int         cyc = 0;

  alu_seq_flags_if #(.WIDTH(W)) bus ();

  alu_seq_flags #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .jump  (jump),
    .flags (flags),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] out;
    logic         z;
    logic         br;
    logic         ill;
    logic [2:0]   f;
    int           at;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           passed = 0;
  int           total = 0;
  logic [W-1:0] m_out = '0;
  logic [2:0]   m_f = 3'b000;

  function void chk(string nm, logic [63:0] got,
                    logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got=%0h want=%0h", nm, got, want);
  endfunction

  // Reference model: returns latency, fills expected response.
  function automatic int predict(input logic [3:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 output exp_t e);
    logic [W-1:0] r;
    logic [2:0]   f;
    logic [63:0]  p;
    longint       s;
    int           lat;
    int           sh;
    r = '0; f = m_f; lat = 1; sh = int'(b[4:0]);
    e.br = 1'b0; e.ill = 1'b0;
    case (op)
      4'd2, 4'd6: begin
        if (op == 4'd2) begin
          r = a + b;
          s = longint'($signed(a)) + longint'($signed(b));
        end else begin
          r = a - b;
          s = longint'($signed(a)) - longint'($signed(b));
        end
        f = {r[W-1],
             (s > 64'sd2147483647) || (s < -64'sd2147483648),
             r == 0};
      end
      4'd7: begin
        r = ($signed(a) < $signed(b)) ? 1 : 0;
        f = 3'b000;
      end
      4'd0, 4'd1, 4'd3, 4'd5: begin
        if (op == 4'd0) r = a & b;
        if (op == 4'd1) r = a | b;
        if (op == 4'd3) r = a ^ b;
        if (op == 4'd5) r = ~(a | b);
        f = {r[W-1], 1'b0, r == 0};
      end
      4'd10, 4'd11: begin
        r = (op == 4'd10) ? a << sh : a >> sh;
        f = {r[W-1], 1'b0, r == 0};
        lat = (sh == 0) ? 1 : sh + 1;
      end
      4'd9: begin
        e.br = m_f[1]; r = m_out; f = 3'b000;
      end
      4'd8: begin
        e.br = m_f[0] | m_f[2]; r = m_out; f = 3'b000;
      end
      4'd12: begin
        if (MUL_EN) begin
          p = {32'd0, a} * {32'd0, b};
          r = p[31:0];
          f = {r[W-1], p[63:32] != 0, r == 0};
          lat = W + 1;
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.out = r; e.z = (r == 0); e.f = f;
    m_out = r; m_f = f;
    return lat;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out_valid cyc=%0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("alu_out", bus.alu_out, mon_e.out);
        chk("zout", bus.zout, mon_e.z);
        chk("branch_taken", bus.branch_taken, mon_e.br);
        chk("illegal", bus.illegal, mon_e.ill);
        chk("flags", flags, mon_e.f);
        chk("latency_cycle", cyc, mon_e.at);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept.
  task automatic issue(input logic [3:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input bit jz, output int waited);
    exp_t e;
    int   lat;
    bus.in_valid = 1'b1;
    bus.alu_control = op;
    bus.a = a;
    bus.b = b;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      total++;
      $display("FAIL accept_timeout op=%0h", op);
    end else begin
      lat = predict(op, a, b, e);
      if (jz) begin e.f = 3'b000; m_f = 3'b000; end
      e.at = cyc + 1 + lat;
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    bus.in_valid = 1'b0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_alu_out"}, bus.alu_out, 0);
    chk({tag, "_zout"}, bus.zout, 0);
    chk({tag, "_branch"}, bus.branch_taken, 0);
    chk({tag, "_illegal"}, bus.illegal, 0);
    chk({tag, "_flags"}, flags, 0);
  endtask

  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.alu_control = 4'd0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd2, 32'h7FFF_FFFF, 32'd1, 0, w);
    issue(4'd9, 32'd0, 32'd0, 0, w);
    idle(2);
    issue(4'd6, 32'd5, 32'd5, 0, w);
    issue(4'd8, 32'd0, 32'd0, 0, w);
    issue(4'd7, 32'hFFFF_FFFF, 32'd3, 0, w);
    idle(2);

    issue(4'd10, 32'd1, 32'd4, 0, w);
    issue(4'd1, 32'd0, 32'd0, 0, w);
    chk("sll_busy_cycles", w, 4);
    drain();

    issue(4'd6, 32'd0, 32'd0, 0, w);
    issue(4'd1, 32'd0, 32'd0, 1, w);
    bus.in_valid = 1'b0;
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    issue(4'd8, 32'd0, 32'd0, 0, w);
    drain();

    issue(4'd12, 32'h0001_0000, 32'h0001_0000, 0, w);
    drain();

    issue(4'd11, 32'h8000_0000, 32'd31, 0, w);
    idle(8);
    chk("busy_mid_shift", busy, 1);
    rst_n = 1'b0;
    q.delete();
    m_out = '0;
    m_f = 3'b000;
    #1;
    chk_reset_outs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", bus.in_ready, 1);
    idle(40);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]   op;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rb = ra;
      issue(op, ra, rb, 0, w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
